// File: rtl/mul4_seq_pkg.sv
// mul4_seq_pkg: state encodings and iteration count for the shift-and-add multiplier
package mul4_seq_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
  localparam int ITER = 4;
endpackage

// File: rtl/sum4.sv
// sum4: 4-bit ripple adder with carry in/out
module sum4 (
  output logic [3:0] S,
  output logic       c_out,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c_in
);
  assign {c_out, S} = {1'b0, A} + {1'b0, B} + {4'b0, c_in};
endmodule

// File: rtl/mul4_seq.sv
// mul4_seq: sequential 4x4 unsigned shift-and-add multiplier with start/busy/done handshake
module mul4_seq
  import mul4_seq_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [7:0]   p,
  output logic         busy,
  output logic         done
);
  if (W != 4) begin : g_bad_w
    $error("mul4_seq: W must be 4");
  end
  state_t      r_state;
  logic [3:0]  r_m, r_acc, r_q;
  logic [1:0]  r_cnt;
  logic [7:0]  r_p;
  logic        r_busy, r_done;
  logic [3:0]  w_s;
  logic        w_c;
  logic [3:0]  w_acc_n, w_q_n;
  sum4 u_sum4 (
    .S    (w_s),
    .c_out(w_c),
    .A    (r_acc),
    .B    (r_q[0] ? r_m : 4'b0000),
    .c_in (1'b0)
  );
  assign w_acc_n = {w_c, w_s[3:1]};
  assign w_q_n   = {w_s[0], r_q[3:1]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'(ITER - 1)) begin
            r_p     <= {w_acc_n, w_q_n};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
  assign p    = r_p;
  assign busy = r_busy;
  assign done = r_done;
endmodule

// File: tb/tb_mul4_seq.sv
// tb_mul4_seq: directed checks of the sequential multiplier handshake, latency and products
module tb_mul4_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic [7:0] p;
  logic       busy, done;
  int total = 0, bad = 0;

  mul4_seq dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .a    (a),
    .b    (b),
    .p    (p),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Call at a negedge; returns at the negedge where done is seen (or after a bounded wait).
  task automatic run_mul(input logic [3:0] ta, input logic [3:0] tb, output logic [7:0] pp,
                         output int lat, output int bc);
    a = ta;
    b = tb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bc = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    if (!done) lat = -1;
    pp = p;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({p, busy, done} !== 10'h000) begin
      bad++;
      $display("FAIL reset_state p=%h busy=%b done=%b want p=00 busy=0 done=0", p, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    logic [7:0] pp;
    int lat, bc;
    run_mul(4'd0, 4'd0, pp, lat, bc);
    total++;
    if (pp !== 8'h00) begin bad++; $display("FAIL zero_prod got %h want 00", pp); end
    total++;
    if (lat !== 5) begin bad++; $display("FAIL zero_latency got %0d want 5", lat); end
    total++;
    if (bc !== 4) begin bad++; $display("FAIL zero_busy_cycles got %0d want 4", bc); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_at_done got %b want 0", busy); end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL zero_done_pulse got %b want 0", done); end
  endtask

  task automatic test_vectors;
    logic [3:0] va [3] = '{4'd15, 4'd13, 4'd1};
    logic [3:0] vb [3] = '{4'd15, 4'd11, 4'd8};
    logic [7:0] vp [3] = '{8'hE1, 8'h8F, 8'h08};
    logic [7:0] pp;
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      run_mul(va[i], vb[i], pp, lat, bc);
      total++;
      if (pp !== vp[i]) begin
        bad++;
        $display("FAIL vector_%0d got %h want %h", i, pp, vp[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pp;
    logic [7:0] want;
    int lat, bc;
    for (int i = 0; i < 256; i++) begin
      run_mul(4'(i >> 4), 4'(i), pp, lat, bc);
      want = 8'((i >> 4) * (i & 15));
      total++;
      if (pp !== want) begin
        bad++;
        $display("FAIL sweep_prod a=%0d b=%0d got %h want %h", i >> 4, i & 15, pp, want);
      end
      total++;
      if (lat !== 5) begin
        bad++;
        $display("FAIL sweep_spacing a=%0d b=%0d got %0d want 5", i >> 4, i & 15, lat);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_in_run;
    int n;
    int extra;
    a = 4'd6;
    b = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd3;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL run_ignore_done got %b want 1", done); end
    total++;
    if (p !== 8'h2A) begin bad++; $display("FAIL run_ignore_prod got %h want 2a", p); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL run_ignore_second_done got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] pp;
    int lat, bc, extra;
    run_mul(4'd9, 4'd9, pp, lat, bc);
    total++;
    if (pp !== 8'h51) begin bad++; $display("FAIL abort_first_prod got %h want 51", pp); end
    @(negedge clk);
    a = 4'd5;
    b = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({p, busy, done} !== 10'h000) begin
      bad++;
      $display("FAIL abort_async p=%h busy=%b done=%b want p=00 busy=0 done=0", p, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL abort_no_done got %0d want 0", extra); end
    total++;
    if (p !== 8'h00) begin bad++; $display("FAIL abort_prod_after got %h want 00", p); end
  endtask

  task automatic test_hold;
    logic [7:0] pp;
    int lat, bc, errs;
    run_mul(4'd9, 4'd9, pp, lat, bc);
    total++;
    if (pp !== 8'h51) begin bad++; $display("FAIL hold_prod got %h want 51", pp); end
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 4'(i * 3 + 1);
      b = 4'(~i);
      if (p !== 8'h51 || done !== 1'b0) errs++;
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL hold_stable got %0d bad cycles want 0", errs); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_vectors;
    test_back_to_back;
    test_start_in_run;
    test_reset_mid_run;
    test_hold;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
